change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Sits downstream of the vending-machine FSM and consumes its change amount once a purchase completes.
- Breaks the amount into physical coins (50, 10, 5, 1) with a greedy largest-first rule, limited by per-denomination inventory counters.
- Releases coins one at a time to the coin-ejector mechanism over a valid/ack handshake.
- Reports completion, or reports a shortfall when exact change cannot be paid.

Parameters:
AMT_W, 8, width of the change amount and of the remaining/short amounts
CNT_W, 8, width of each inventory counter (saturates at 2^CNT_W-1)
INIT_50, 10, inventory of 50-coins after reset
INIT_10, 20, inventory of 10-coins after reset
INIT_5, 20, inventory of 5-coins after reset
INIT_1, 40, inventory of 1-coins after reset

Ports:
clk  input  1  system clock, all logic on the rising edge
reset  input  1  synchronous, active-high reset
change_valid  input  1  FSM presents a change request
change_amount  input  AMT_W  change to pay out, in units of 1
change_ready  output  1  high only in IDLE; request accepted when change_valid && change_ready
coin_valid  output  1  a coin is offered to the ejector
coin_value  output  6  denomination offered (50/10/5/1); 0 when coin_valid=0
coin_ack  input  1  ejector took the coin; only meaningful while coin_valid=1
done  output  1  one-cycle pulse: full amount paid
short  output  1  one-cycle pulse: payout stopped because of missing inventory
short_amount  output  AMT_W  unpaid remainder; valid when short=1, held until the next acceptance
refill_en  input  1  add coins to one inventory counter this cycle
refill_sel  input  2  0=50, 1=10, 2=5, 3=1
refill_count  input  CNT_W  number of coins added
empty  output  4  bit i set when the counter selected by refill_sel=i is zero

Behaviour:
- Reset, which overrides everything including a payout in progress:
  - state=IDLE; change_ready=1 from the first cycle after reset.
  - coin_valid=0, coin_value=0, done=0, short=0, short_amount=0, remaining=0.
  - Counters are loaded with their INIT_* values.
  - A coin offered but not yet acked when reset arrives is abandoned, with no counter decrement.
- States: IDLE, SELECT, DISPENSE, DONE, SHORT.
- IDLE:
  - On acceptance: remaining<=change_amount, short_amount<=0, next state SELECT.
  - change_valid while not in IDLE is ignored (no queueing).
- SELECT (one cycle):
  - If remaining==0, go to DONE.
  - Otherwise pick the largest d in {50,10,5,1} with d<=remaining and cnt_d>0, latch it into coin_value, and go to DISPENSE.
  - If no d qualifies, go to SHORT.
- DISPENSE:
  - coin_valid=1; coin_value stays stable until the ack.
  - On the cycle coin_ack=1: remaining<=remaining-d, cnt_d<=cnt_d-1, coin_valid drops next cycle, and the next state is SELECT.
  - With no ack, the block waits indefinitely.
- DONE: done=1 for exactly one cycle, then IDLE.
- SHORT: short=1 for exactly one cycle with short_amount=remaining, then IDLE.
- Latency:
  - Acceptance in cycle T gives SELECT in T+1 and coin_valid in T+2.
  - Each ack adds one SELECT cycle before the next coin.
  - Amount 0 gives done at T+2.
- Refill:
  - Accepted in any state.
  - Counter update: cnt+refill_count, saturating at max.
  - If a refill and an ack decrement hit the same counter in the same cycle, the result is sat(cnt+refill_count)-1, with saturation applied before the decrement.
  - A refill that lands during SELECT is seen from the next SELECT evaluation onward.
- Arithmetic:
  - remaining never underflows, because d<=remaining is guaranteed by SELECT.
  - A counter is never decremented below 0.
- coin_ack while coin_valid=0 is ignored.

Test Plan:
- Reset, then request 87 with default inventory, ack each coin on the cycle after coin_valid rises -> coins 50,10,10,10,5,1,1 in order; done one cycle after the last SELECT; counters end at 9/17/19/38.
- Request 0 -> no coin_valid; done pulses at T+2; change_ready back high at T+3.
- Preload the 10-counter to 0 via reset plus manual depletion, then request 20 -> coins 5,5,5,5; done; no short.
- Request 3 with the 1-counter at 2 and the 5-counter at 0 -> coins 1,1, then short=1 with short_amount=1.
- Hold coin_ack low for 10 cycles -> coin_valid and coin_value stay stable and counters are unchanged; reset asserted mid-wait -> IDLE next cycle, coin_valid=0, counters back to INIT_*.
- refill_en for the 1-counter with count 5 on the same cycle as an ack of a 1-coin at cnt=3 -> counter reads 7; refill of 255 at cnt=200 -> counter saturates at 255.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: greedy largest-first payout of a change amount into 50/10/5/1 coins,
// limited by per-denomination inventory, released one coin at a time over a valid/ack handshake.
module change_dispenser #(
    parameter int unsigned AMT_W   = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned INIT_50 = 10,
    parameter int unsigned INIT_10 = 20,
    parameter int unsigned INIT_5  = 20,
    parameter int unsigned INIT_1  = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amount,
    output logic             change_ready,
    output logic             coin_valid,
    output logic [5:0]       coin_value,
    input  logic             coin_ack,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] short_amount,
    input  logic             refill_en,
    input  logic [1:0]       refill_sel,
    input  logic [CNT_W-1:0] refill_count,
    output logic [3:0]       empty
);

    localparam int unsigned VAL_W  = 6;
    localparam int unsigned N_DENOM = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_DISPENSE,
        S_DONE,
        S_SHORT
    } state_e;

    state_e           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [AMT_W-1:0] short_amount_q, short_amount_d;
    logic [1:0]       sel_q, sel_d;
    logic [VAL_W-1:0] coin_value_q, coin_value_d;
    logic             change_ready_q, change_ready_d;
    logic             coin_valid_q, coin_valid_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic [3:0]       empty_q, empty_d;
    logic [CNT_W-1:0] cnt_q [N_DENOM];
    logic [CNT_W-1:0] cnt_d [N_DENOM];

    logic             dec_en;
    logic             pick_found;
    logic [1:0]       pick_sel;

    // Index 0..3 maps to 50/10/5/1, matching refill_sel encoding.
    function automatic logic [VAL_W-1:0] denom(input logic [1:0] idx);
        case (idx)
            2'd0:    denom = VAL_W'(50);
            2'd1:    denom = VAL_W'(10);
            2'd2:    denom = VAL_W'(5);
            default: denom = VAL_W'(1);
        endcase
    endfunction

    // Largest denomination that fits the remainder and is in stock; index 0 wins last.
    always_comb begin
        pick_found = 1'b0;
        pick_sel   = 2'd0;
        for (int i = N_DENOM - 1; i >= 0; i--) begin
            if ((AMT_W'(denom(2'(i))) <= remaining_q) && (cnt_q[i] != '0)) begin
                pick_found = 1'b1;
                pick_sel   = 2'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        short_amount_d = short_amount_q;
        sel_d          = sel_q;
        coin_value_d   = coin_value_q;
        dec_en         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (change_valid && change_ready_q) begin
                    remaining_d    = change_amount;
                    short_amount_d = '0;
                    state_d        = S_SELECT;
                end
            end
            S_SELECT: begin
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else if (pick_found) begin
                    sel_d        = pick_sel;
                    coin_value_d = denom(pick_sel);
                    state_d      = S_DISPENSE;
                end else begin
                    short_amount_d = remaining_q;
                    state_d        = S_SHORT;
                end
            end
            S_DISPENSE: begin
                if (coin_ack) begin
                    remaining_d  = remaining_q - AMT_W'(coin_value_q);
                    coin_value_d = '0;
                    dec_en       = 1'b1;
                    state_d      = S_SELECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_SHORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        change_ready_d = (state_d == S_IDLE);
        coin_valid_d   = (state_d == S_DISPENSE);
        done_d         = (state_d == S_DONE);
        short_d        = (state_d == S_SHORT);
    end

    // Refill saturates first, then a same-cycle ack decrement is applied.
    always_comb begin
        logic [CNT_W:0]   add;
        logic [CNT_W:0]   sum;
        logic [CNT_W-1:0] sat;
        add = '0;
        sum = '0;
        sat = '0;
        for (int i = 0; i < N_DENOM; i++) begin
            add = (refill_en && (refill_sel == 2'(i))) ? {1'b0, refill_count} : '0;
            sum = {1'b0, cnt_q[i]} + add;
            sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            if (dec_en && (sel_q == 2'(i)) && (sat != '0)) begin
                sat = sat - CNT_W'(1);
            end
            cnt_d[i]   = sat;
            empty_d[i] = (sat == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            remaining_q    <= '0;
            short_amount_q <= '0;
            sel_q          <= '0;
            coin_value_q   <= '0;
            change_ready_q <= 1'b1;
            coin_valid_q   <= 1'b0;
            done_q         <= 1'b0;
            short_q        <= 1'b0;
            cnt_q[0]       <= CNT_W'(INIT_50);
            cnt_q[1]       <= CNT_W'(INIT_10);
            cnt_q[2]       <= CNT_W'(INIT_5);
            cnt_q[3]       <= CNT_W'(INIT_1);
            empty_q        <= {INIT_1 == 0, INIT_5 == 0, INIT_10 == 0, INIT_50 == 0};
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            short_amount_q <= short_amount_d;
            sel_q          <= sel_d;
            coin_value_q   <= coin_value_d;
            change_ready_q <= change_ready_d;
            coin_valid_q   <= coin_valid_d;
            done_q         <= done_d;
            short_q        <= short_d;
            for (int i = 0; i < N_DENOM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            empty_q        <= empty_d;
        end
    end

    assign change_ready = change_ready_q;
    assign coin_valid   = coin_valid_q;
    assign coin_value   = coin_value_q;
    assign done         = done_q;
    assign short        = short_q;
    assign short_amount = short_amount_q;
    assign empty        = empty_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy inventory model predicts coins and outcomes.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       change_ready;
    logic       coin_valid;
    logic [5:0] coin_value;
    logic       coin_ack;
    logic       done;
    logic       short;
    logic [7:0] short_amount;
    logic       refill_en;
    logic [1:0] refill_sel;
    logic [7:0] refill_count;
    logic [3:0] empty;

    typedef struct {
        bit is_short;
        int amt;
    } end_t;

    int   exp_coin_q [$];
    end_t exp_end_q  [$];
    int   m_cnt [4];
    int   n_checks = 0;
    int   n_errors = 0;

    change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .change_valid (change_valid),
        .change_amount(change_amount),
        .change_ready (change_ready),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .coin_ack     (coin_ack),
        .done         (done),
        .short        (short),
        .short_amount (short_amount),
        .refill_en    (refill_en),
        .refill_sel   (refill_sel),
        .refill_count (refill_count),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int denom_val(input int i);
        case (i)
            0:       return 50;
            1:       return 10;
            2:       return 5;
            default: return 1;
        endcase
    endfunction

    // Predict the coin sequence and final outcome, consuming model inventory.
    function automatic void model_request(input int amt);
        int rem;
        int pick;
        end_t e;
        rem = amt;
        forever begin
            if (rem == 0) begin
                e.is_short = 1'b0;
                e.amt = 0;
                exp_end_q.push_back(e);
                return;
            end
            pick = -1;
            for (int i = 0; i < 4 && pick < 0; i++)
                if (denom_val(i) <= rem && m_cnt[i] > 0) pick = i;
            if (pick < 0) begin
                e.is_short = 1'b1;
                e.amt = rem;
                exp_end_q.push_back(e);
                return;
            end
            exp_coin_q.push_back(denom_val(pick));
            m_cnt[pick]--;
            rem -= denom_val(pick);
        end
    endfunction

    function automatic void model_refill(input int sel, input int cnt);
        m_cnt[sel] = (m_cnt[sel] + cnt > 255) ? 255 : m_cnt[sel] + cnt;
    endfunction

    task automatic check_counters();
        int exp_empty;
        exp_empty = 0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("cnt%0d", i), int'(dut.cnt_q[i]), m_cnt[i]);
            if (m_cnt[i] == 0) exp_empty |= (1 << i);
        end
        check_eq("empty", int'(empty), exp_empty);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        change_valid = 1'b0;
        coin_ack = 1'b0;
        refill_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_cnt = '{10, 20, 20, 40};
        exp_coin_q.delete();
        exp_end_q.delete();
    endtask

    task automatic do_refill(input int sel, input int cnt);
        refill_en = 1'b1;
        refill_sel = 2'(sel);
        refill_count = 8'(cnt);
        @(negedge clk);
        refill_en = 1'b0;
        model_refill(sel, cnt);
    endtask

    // Starts and ends on a negedge with the DUT idle.
    task automatic do_request(input int amt, input int delay, input int refill_ack);
        bit   fin;
        bit   first;
        int   waited;
        end_t e;
        model_request(amt);
        if (refill_ack > 0) model_refill(3, refill_ack);
        check_eq("ready_before", int'(change_ready), 1);
        change_valid = 1'b1;
        change_amount = 8'(amt);
        @(negedge clk);
        change_valid = 1'b0;
        fin = 1'b0;
        first = 1'b1;
        waited = 0;
        for (int c = 1; c <= 600 && !fin; c++) begin
            coin_ack = 1'b0;
            refill_en = 1'b0;
            if (done || short) begin
                if (first) check_eq("first_latency", c, 2);
                first = 1'b0;
                if (exp_end_q.size() == 0) begin
                    check_eq("end_queue", 0, 1);
                end else begin
                    e = exp_end_q.pop_front();
                    check_eq("short_flag", int'(short), int'(e.is_short));
                    check_eq("done_flag", int'(done), int'(!e.is_short));
                    if (e.is_short) check_eq("short_amount", int'(short_amount), e.amt);
                end
                fin = 1'b1;
            end else if (coin_valid) begin
                if (first) check_eq("first_latency", c, 2);
                first = 1'b0;
                if (exp_coin_q.size() == 0) begin
                    check_eq("extra_coin", int'(coin_value), 0);
                    coin_ack = 1'b1;
                end else begin
                    check_eq("coin_value", int'(coin_value), exp_coin_q[0]);
                    if (waited < delay) begin
                        waited++;
                    end else begin
                        void'(exp_coin_q.pop_front());
                        coin_ack = 1'b1;
                        waited = 0;
                        if (refill_ack > 0) begin
                            refill_en = 1'b1;
                            refill_sel = 2'd3;
                            refill_count = 8'(refill_ack);
                        end
                    end
                end
            end else begin
                check_eq("coin_value_idle", int'(coin_value), 0);
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) check_eq("timeout", 0, 1);
        check_eq("coins_left", exp_coin_q.size(), 0);
        exp_coin_q.delete();
        @(negedge clk);
        check_eq("ready_after", int'(change_ready), 1);
        check_eq("done_cleared", int'(done), 0);
        check_counters();
    endtask

    initial begin
        reset = 1'b1;
        change_valid = 1'b0;
        change_amount = '0;
        coin_ack = 1'b0;
        refill_en = 1'b0;
        refill_sel = '0;
        refill_count = '0;

        do_reset();
        check_eq("rst_ready", int'(change_ready), 1);
        check_eq("rst_coin_valid", int'(coin_valid), 0);
        check_eq("rst_coin_value", int'(coin_value), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_short", int'(short), 0);
        check_eq("rst_short_amount", int'(short_amount), 0);
        check_counters();

        do_request(87, 0, 0);
        check_eq("after87_c50", int'(dut.cnt_q[0]), 9);
        check_eq("after87_c10", int'(dut.cnt_q[1]), 17);
        check_eq("after87_c5", int'(dut.cnt_q[2]), 19);
        check_eq("after87_c1", int'(dut.cnt_q[3]), 38);

        do_request(0, 0, 0);

        // Drain the 10s, then pay 20 from 5s.
        do_reset();
        for (int k = 0; k < 5; k++) do_request(40, 0, 0);
        check_eq("tens_empty", int'(dut.cnt_q[1]), 0);
        do_request(20, 1, 0);

        // Drain 5s and leave two 1s, then ask for 3.
        do_request(45, 0, 0);
        do_request(35, 0, 0);
        do_request(38, 0, 0);
        do_request(3, 0, 0);
        check_eq("short_amount_held", int'(short_amount), 1);
        check_eq("empty_after_short", int'(empty), 4'b1110);

        // Refill on the same cycle as an ack of the same denomination.
        do_refill(3, 3);
        do_request(1, 0, 5);
        check_eq("refill_ack_c1", int'(dut.cnt_q[3]), 7);

        do_refill(3, 193);
        check_eq("refill_c1_200", int'(dut.cnt_q[3]), 200);
        do_refill(3, 255);
        check_eq("refill_sat", int'(dut.cnt_q[3]), 255);
        check_counters();

        // Stalled ejector, then reset during the wait.
        change_valid = 1'b1;
        change_amount = 8'd7;
        @(negedge clk);
        change_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check_eq("stall_valid", int'(coin_valid), 1);
            check_eq("stall_value", int'(coin_value), 1);
            @(negedge clk);
        end
        check_eq("stall_c1", int'(dut.cnt_q[3]), 255);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_coin_valid", int'(coin_valid), 0);
        check_eq("midrst_ready", int'(change_ready), 1);
        check_eq("midrst_c50", int'(dut.cnt_q[0]), 10);
        check_eq("midrst_c10", int'(dut.cnt_q[1]), 20);
        check_eq("midrst_c5", int'(dut.cnt_q[2]), 20);
        check_eq("midrst_c1", int'(dut.cnt_q[3]), 40);
        reset = 1'b0;
        m_cnt = '{10, 20, 20, 40};

        // Random requests with random stalls and refills.
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 1) == 1) do_refill(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
            do_request(int'($urandom_range(0, 140)), int'($urandom_range(0, 2)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
